// File: rtl/strm_io2g_ingress_pkg.sv
// rtl/strm_io2g_ingress_pkg.sv - global-buffer stream constants, ingress state type and mode helper
package strm_io2g_ingress_pkg;

  localparam logic [1:0] ST_DMA_VALID_MODE_VALID       = 2'd0;
  localparam logic [1:0] ST_DMA_VALID_MODE_READY_VALID = 2'd1;
  localparam logic [1:0] ST_DMA_VALID_MODE_STATIC      = 2'd2;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;
  localparam int WORD_W = 16;
  localparam int PACK_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ingress_state_e;

  // Only READY_VALID gates acceptance on io1_g2io; the reserved encoding behaves as VALID.
  function automatic logic mode_uses_ready(input logic [1:0] mode);
    case (mode)
      ST_DMA_VALID_MODE_READY_VALID: return 1'b1;
      ST_DMA_VALID_MODE_VALID,
      ST_DMA_VALID_MODE_STATIC:      return 1'b0;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/strm_pack_fifo.sv
// rtl/strm_pack_fifo.sv - first-word-fall-through FIFO for packed words with occupancy count
module strm_pack_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic                       rd_vld_o,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign rd_vld_o  = (count_q != '0);
  assign rd_data_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/strm_io2g_ingress.sv
// rtl/strm_io2g_ingress.sv - packs 16-bit CGRA stream words into 64-bit lanes for the store DMA
module strm_io2g_ingress
  import strm_io2g_ingress_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          cfg_mode,
  input  logic [15:0]         cfg_num_words,
  input  logic                start,
  input  logic                flush,
  input  logic                io1_io2g,
  input  logic [WORD_W-1:0]   io16_io2g,
  output logic                io1_g2io,
  output logic                wr_vld,
  output logic [PACK_W-1:0]   wr_data,
  output logic [LANES-1:0]    wr_strb,
  input  logic                wr_rdy,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ingress_state_e state_q, state_d;

  logic [15:0]        word_cnt_q, num_words_q;
  logic [PACK_W-1:0]  pack_q, pack_merged;
  logic [LANES-1:0]   pack_strb_q, strb_merged;
  logic               overflow_q, zero_done_q;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_pop, fifo_can_push;
  logic [LANE_W-1:0]  lane;
  logic               start_ok, accept, last_word, pack_now, push, drop;

  assign fifo_empty    = (fifo_count == '0);
  assign fifo_pop      = wr_vld && wr_rdy;
  assign fifo_can_push = (fifo_count != CNT_W'(FIFO_DEPTH)) || fifo_pop;

  assign start_ok  = start && !flush && (state_q == ST_IDLE);
  assign accept    = (state_q == ST_RUN) && io1_io2g &&
                     (mode_uses_ready(cfg_mode) ? io1_g2io : 1'b1);
  assign lane      = word_cnt_q[LANE_W-1:0];
  assign last_word = ((word_cnt_q + 16'd1) == num_words_q);
  assign pack_now  = accept && ((lane == LANE_W'(LANES - 1)) || last_word);
  assign push      = pack_now && fifo_can_push;
  assign drop      = pack_now && !fifo_can_push;

  // The current word is merged combinationally so a full packer pushes in its own cycle.
  always_comb begin
    pack_merged                          = pack_q;
    pack_merged[lane*WORD_W +: WORD_W]   = io16_io2g;
    strb_merged                          = pack_strb_q;
    strb_merged[lane]                    = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && cfg_num_words != 16'd0) state_d = ST_RUN;
      ST_RUN:   if (accept && last_word)             state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty)                      state_d = ST_IDLE;
      default:                                       state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    io1_g2io = (state_q == ST_RUN) && (fifo_count < CNT_W'(FIFO_DEPTH));
    done     = !flush && (zero_done_q || ((state_q == ST_DRAIN) && fifo_empty));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_q  <= '0;
      num_words_q <= '0;
      pack_q      <= '0;
      pack_strb_q <= '0;
      overflow_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else if (flush) begin
      word_cnt_q  <= '0;
      pack_q      <= '0;
      pack_strb_q <= '0;
      overflow_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= start_ok && (cfg_num_words == 16'd0);
      if (start_ok) begin
        num_words_q <= cfg_num_words;
        word_cnt_q  <= '0;
        pack_q      <= '0;
        pack_strb_q <= '0;
        overflow_q  <= 1'b0;
      end
      if (accept) begin
        word_cnt_q <= word_cnt_q + 16'd1;
        if (pack_now) begin
          pack_q      <= '0;
          pack_strb_q <= '0;
        end else begin
          pack_q      <= pack_merged;
          pack_strb_q <= strb_merged;
        end
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

  strm_pack_fifo #(
    .WIDTH (PACK_W + LANES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush),
    .push_i      (push),
    .push_data_i ({strb_merged, pack_merged}),
    .pop_i       (fifo_pop),
    .rd_vld_o    (wr_vld),
    .rd_data_o   ({wr_strb, wr_data}),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_strm_io2g_ingress.sv
// tb/tb_strm_io2g_ingress.sv - randomized self-checking bench with a word-list packing model
module tb_strm_io2g_ingress;

  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_num_words = 16'd0;
  logic        start = 1'b0, flush = 1'b0, io1_io2g = 1'b0, wr_rdy = 1'b1;
  logic [15:0] io16_io2g = 16'd0;
  logic        io1_g2io, wr_vld, busy, done, overflow;
  logic [63:0] wr_data;
  logic [3:0]  wr_strb;

  int n_err = 0, n_checks = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, last_pop_cyc = -1;
  bit any_vld = 1'b0;
  logic [63:0] got_d[$];
  logic [3:0]  got_s[$];
  logic [15:0] words[$];

  strm_io2g_ingress #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_mode      (cfg_mode),
    .cfg_num_words (cfg_num_words),
    .start         (start),
    .flush         (flush),
    .io1_io2g      (io1_io2g),
    .io16_io2g     (io16_io2g),
    .io1_g2io      (io1_g2io),
    .wr_vld        (wr_vld),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_rdy        (wr_rdy),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (wr_vld) any_vld = 1'b1;
      if (wr_vld && wr_rdy) begin
        got_d.push_back(wr_data);
        got_s.push_back(wr_strb);
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  // Expected writes come straight from the word list: groups of four, last group partial.
  task automatic run_stream(input logic [1:0] mode, input int rdy_pct, input int v_pct,
                            input int hold, input int keep, input int exp_ovf_idx,
                            input string tag);
    int n, idx, t, ovf_idx, m;
    logic acc;
    logic [63:0] ed;
    logic [3:0]  es;
    n = words.size();
    got_d.delete();
    got_s.delete();
    done_cnt = 0; done_cyc = -1; last_pop_cyc = -1;
    @(posedge clk); #1;
    cfg_mode = mode; cfg_num_words = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; t = 0; ovf_idx = -1;
    while (idx < n && t < 3000) begin
      io1_io2g  = ($urandom_range(0, 99) < v_pct);
      io16_io2g = words[idx];
      wr_rdy    = (t < hold) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (overflow && ovf_idx < 0) ovf_idx = idx;
      acc = io1_io2g && ((mode != 2'd1) || io1_g2io);
      @(posedge clk); #1;
      if (acc) idx++;
      t++;
      if (mode == 2'd1 && t == hold) begin
        check({tag, " accepts while stalled"}, 64'(idx), 64'(4 * DEPTH));
        check({tag, " ready while stalled"}, 64'(io1_g2io), 64'd0);
      end
    end
    io1_io2g = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      wr_rdy = ($urandom_range(0, 99) < rdy_pct);
      @(posedge clk); #1;
      t++;
    end
    if (ovf_idx < 0 && overflow) ovf_idx = n;
    wr_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, " write count"}, 64'(got_d.size()), 64'(keep));
    m = (got_d.size() < keep) ? got_d.size() : keep;
    for (int p = 0; p < m; p++) begin
      ed = '0; es = '0;
      for (int j = 0; j < 4; j++) begin
        if (p * 4 + j < n) begin
          ed[j*16 +: 16] = words[p*4 + j];
          es[j] = 1'b1;
        end
      end
      check($sformatf("%s data[%0d]", tag, p), got_d[p], ed);
      check($sformatf("%s strb[%0d]", tag, p), 64'(got_s[p]), 64'(es));
    end
    check({tag, " done count"}, 64'(done_cnt), 64'd1);
    check({tag, " done after last pop"}, 64'(done_cyc - last_pop_cyc), 64'd1);
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf_idx >= 0));
    check({tag, " overflow word"}, 64'(ovf_idx), 64'(exp_ovf_idx));
    check({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n, md;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset wr_vld", 64'(wr_vld), 64'd0);
    check("reset wr_data", wr_data, 64'd0);
    check("reset wr_strb", 64'(wr_strb), 64'd0);
    check("reset ready", 64'(io1_g2io), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // zero-length stream
    any_vld = 1'b0; done_cnt = 0;
    @(posedge clk); #1;
    cfg_mode = 2'd0; cfg_num_words = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero done pulse", 64'(done), 64'd1);
    check("zero busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("zero done count", 64'(done_cnt), 64'd1);
    check("zero no write", 64'(any_vld), 64'd0);

    fill_random(8);
    run_stream(2'd1, 100, 100, 0, 2, -1, "rv8");

    words.delete();
    for (int i = 1; i <= 6; i++) words.push_back(16'(i));
    run_stream(2'd0, 100, 100, 0, 2, -1, "valid6");

    fill_random(32);
    run_stream(2'd1, 100, 100, 40, 8, -1, "rv stall");

    fill_random(32);
    run_stream(2'd0, 100, 100, 40, DEPTH, 4 * (DEPTH + 1), "valid ovf");

    // flush mid-stream, then a clean short stream
    fill_random(16);
    done_cnt = 0;
    @(posedge clk); #1;
    cfg_mode = 2'd0; cfg_num_words = 16'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      io1_io2g = 1'b1; io16_io2g = words[i];
      @(posedge clk); #1;
    end
    io1_io2g = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush wr_vld", 64'(wr_vld), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("flush no done", 64'(done_cnt), 64'd0);
    fill_random(4);
    run_stream(2'd0, 100, 100, 0, 1, -1, "post flush");

    // reset in the middle of a stream
    fill_random(8);
    done_cnt = 0;
    @(posedge clk); #1;
    cfg_mode = 2'd0; cfg_num_words = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io1_io2g = 1'b1; io16_io2g = words[i];
      @(posedge clk); #1;
    end
    io1_io2g = 1'b0; reset = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset wr_vld", 64'(wr_vld), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midreset no done", 64'(done_cnt), 64'd0);

    for (int k = 0; k < 6; k++) begin
      md = $urandom_range(0, 3);
      n  = $urandom_range(1, 23);
      fill_random(n);
      run_stream(2'(md), (md == 1) ? $urandom_range(30, 100) : 100,
                 $urandom_range(40, 100), 0, (n + 3) / 4, -1,
                 $sformatf("rand%0d m%0d n%0d", k, md, n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
